// File: rtl/otp_pkg.sv
// Shared definitions for the OTP array model and its controller:
// bias-line encodings, array state enum and small elaboration helpers.
package otp_pkg;

   // Per-column PL pair encodings
   localparam logic [1:0] PL_IDLE    = 2'b00;
   localparam logic [1:0] PL_READ    = 2'b01;
   localparam logic [1:0] PL_PROG    = 2'b10;
   localparam logic [1:0] PL_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PROG  = 3'd1,
      ST_DONE  = 3'd2,
      ST_READ  = 3'd3,
      ST_FAULT = 3'd4
   } otp_state_e;

   function automatic int otp_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Column index width; a single-column array still gets one bit
   function automatic int otp_col_w(input int b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction

endpackage

// File: rtl/otp_bias_decode.sv
// Combinational decode of the array bias/select lines into qualified
// program/read conditions, the illegal-bias flag and the selected column.
module otp_bias_decode
   import otp_pkg::*;
#(
   parameter int A     = 2,
   parameter int B     = 2,
   parameter int COL_W = 1
) (
   input  logic [2*B-1:0]   pl,
   input  logic [B-1:0]     bl,
   input  logic [A-1:0]     wlp,
   input  logic             prg,
   output logic             prog_ok,
   output logic             read_ok,
   output logic             illegal,
   output logic [COL_W-1:0] col
);

   logic       bl_onehot_s;
   logic       bl_active_s;
   logic       any_ill_s;
   logic       any_read_s;
   logic       other_busy_s;
   logic [1:0] sel_pair_s;

   // Scan every column pair: illegal/read bias anywhere, the selected pair,
   // and whether any unselected column carries non-idle bias
   always_comb begin
      any_ill_s    = 1'b0;
      any_read_s   = 1'b0;
      other_busy_s = 1'b0;
      sel_pair_s   = PL_IDLE;
      col          = {COL_W{1'b0}};
      bl_active_s  = (bl != {B{1'b0}});
      bl_onehot_s  = bl_active_s && ((bl & (bl - {{(B-1){1'b0}}, 1'b1})) == {B{1'b0}});
      for (int i = 0; i < B; i++) begin
         any_ill_s    = any_ill_s  | (pl[2*i +: 2] == PL_ILLEGAL);
         any_read_s   = any_read_s | (pl[2*i +: 2] == PL_READ);
         other_busy_s = other_busy_s | (!bl[i] && (pl[2*i +: 2] != PL_IDLE));
         sel_pair_s   = bl[i] ? pl[2*i +: 2] : sel_pair_s;
         col          = bl[i] ? COL_W'(i) : col;
      end
      prog_ok = prg && bl_onehot_s && (sel_pair_s == PL_PROG) &&
                (wlp != {A{1'b0}}) && !other_busy_s;
      read_ok = !prg && bl_onehot_s && (sel_pair_s == PL_READ) && !other_busy_s;
      illegal = any_ill_s || (prg && any_read_s) ||
                (bl_active_s && !bl_onehot_s && (pl != {(2*B){1'b0}}));
   end

endmodule

// File: rtl/otp_array_model.sv
// Cycle-accurate A x B OTP fuse array: qualifies program pulses, commits
// fuse bits (set-only), senses reads and latches illegal bias as a fault.
module otp_array_model
   import otp_pkg::*;
#(
   parameter int A           = 2,
   parameter int B           = 2,
   parameter int PROG_CYCLES = 4,
   parameter int READ_LAT    = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2*B-1:0] PL,
   input  logic [B-1:0]   BL,
   input  logic [A-1:0]   WLN,
   input  logic [A-1:0]   WLP,
   input  logic           PRG,
   output logic           writing_successful,
   output logic [A-1:0]   sense_out,
   output logic           sense_valid,
   output logic           fault
);

   localparam int COL_W = otp_col_w(B);
   localparam int CNT_W = $clog2(otp_max(PROG_CYCLES, READ_LAT) + 1);
   localparam logic [CNT_W-1:0] PROG_CNT = CNT_W'(PROG_CYCLES);
   localparam logic [CNT_W-1:0] READ_CNT = CNT_W'(READ_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             prog_ok_s, read_ok_s, illegal_s;
   logic [COL_W-1:0] col_s;

   otp_state_e           state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [A-1:0]         wlp_q, wlp_d;
   logic [B-1:0][A-1:0]  fuse_q, fuse_d;
   logic                 ws_q, ws_d;
   logic [A-1:0]         sense_q, sense_d;
   logic                 valid_q, valid_d;
   logic                 fault_q, fault_d;

   otp_bias_decode #(.A(A), .B(B), .COL_W(COL_W)) u_decode (
      .pl      (PL),
      .bl      (BL),
      .wlp     (WLP),
      .prg     (PRG),
      .prog_ok (prog_ok_s),
      .read_ok (read_ok_s),
      .illegal (illegal_s),
      .col     (col_s)
   );

   // Next-state, fuse commit and registered-output computation
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      col_d   = col_q;
      wlp_d   = wlp_q;
      fuse_d  = fuse_q;
      ws_d    = 1'b0;
      sense_d = {A{1'b0}};
      valid_d = 1'b0;
      fault_d = 1'b0;
      if (illegal_s || (state_q == ST_FAULT)) begin
         // Illegal bias wins over everything and is only cleared by reset
         state_d = ST_FAULT;
         count_d = {CNT_W{1'b0}};
         fault_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (prog_ok_s) begin
                  col_d   = col_s;
                  wlp_d   = WLP;
                  count_d = CNT_ONE;
                  if (CNT_ONE >= PROG_CNT) begin
                     fuse_d[col_s] = fuse_q[col_s] | WLP;
                     ws_d          = 1'b1;
                     state_d       = ST_DONE;
                  end else begin
                     state_d = ST_PROG;
                  end
               end else if (read_ok_s) begin
                  col_d   = col_s;
                  count_d = CNT_ONE;
                  state_d = ST_READ;
                  if (CNT_ONE >= READ_CNT) begin
                     valid_d = 1'b1;
                     sense_d = fuse_q[col_s] & WLN;
                  end else begin
                     valid_d = 1'b0;
                  end
               end else begin
                  count_d = {CNT_W{1'b0}};
               end
            end
            ST_PROG: begin
               if (prog_ok_s && (col_s == col_q) && (WLP == wlp_q)) begin
                  count_d = count_q + CNT_ONE;
                  if (count_d >= PROG_CNT) begin
                     fuse_d[col_q] = fuse_q[col_q] | wlp_q;
                     ws_d          = 1'b1;
                     state_d       = ST_DONE;
                  end else begin
                     state_d = ST_PROG;
                  end
               end else begin
                  state_d = ST_IDLE;
                  count_d = {CNT_W{1'b0}};
               end
            end
            ST_DONE: begin
               // Hold here while PRG stays up so one long pulse commits once
               if (PRG) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
                  count_d = {CNT_W{1'b0}};
               end
            end
            ST_READ: begin
               if (read_ok_s && (col_s == col_q)) begin
                  count_d = (count_q >= READ_CNT) ? READ_CNT : (count_q + CNT_ONE);
                  if (count_d >= READ_CNT) begin
                     valid_d = 1'b1;
                     sense_d = fuse_q[col_q] & WLN;
                  end else begin
                     valid_d = 1'b0;
                  end
               end else begin
                  state_d = ST_IDLE;
                  count_d = {CNT_W{1'b0}};
               end
            end
            default: begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
            end
         endcase
      end
   end

   // State, fuse storage and output registers; reset blanks the array
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= {CNT_W{1'b0}};
         col_q   <= {COL_W{1'b0}};
         wlp_q   <= {A{1'b0}};
         fuse_q  <= {(A*B){1'b0}};
         ws_q    <= 1'b0;
         sense_q <= {A{1'b0}};
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         col_q   <= col_d;
         wlp_q   <= wlp_d;
         fuse_q  <= fuse_d;
         ws_q    <= ws_d;
         sense_q <= sense_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign writing_successful = ws_q;
   assign sense_out          = sense_q;
   assign sense_valid        = valid_q;
   assign fault              = fault_q;

endmodule

// File: tb/tb_otp_array_model.sv
// Directed bench for otp_array_model (A=2, B=2, PROG_CYCLES=4, READ_LAT=2).
// Expected outputs {writing_successful, sense_out[1:0], sense_valid, fault}
// are queued when each step is driven and checked after the clock edge.
module tb_otp_array_model;

   logic       clk;
   logic       reset;
   logic [3:0] PL;
   logic [1:0] BL;
   logic [1:0] WLN;
   logic [1:0] WLP;
   logic       PRG;
   logic       writing_successful;
   logic [1:0] sense_out;
   logic       sense_valid;
   logic       fault;

   int total = 0;
   int bad   = 0;

   logic [4:0] exp_q[$];
   string      tag_q[$];

   otp_array_model #(.A(2), .B(2), .PROG_CYCLES(4), .READ_LAT(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .PL                 (PL),
      .BL                 (BL),
      .WLN                (WLN),
      .WLP                (WLP),
      .PRG                (PRG),
      .writing_successful (writing_successful),
      .sense_out          (sense_out),
      .sense_valid        (sense_valid),
      .fault              (fault)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pop the oldest expectation and compare it against the DUT outputs
   task automatic check_head();
      logic [4:0] got;
      logic [4:0] ex;
      string      tg;
      ex  = exp_q.pop_front();
      tg  = tag_q.pop_front();
      got = {writing_successful, sense_out, sense_valid, fault};
      total++;
      assert (got === ex) else begin
         bad++;
         $error("FAIL %s: got ws/so/sv/fault=%b required %b", tg, got, ex);
      end
   endtask

   // One clock step: drive at negedge, queue expectation, check #1 after posedge
   task automatic cyc(input logic [3:0] pl, input logic [1:0] bl,
                      input logic [1:0] wln, input logic [1:0] wlp,
                      input logic prg, input logic [4:0] ex, input string tag);
      @(negedge clk);
      PL  = pl;
      BL  = bl;
      WLN = wln;
      WLP = wlp;
      PRG = prg;
      exp_q.push_back(ex);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_head();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      PL = 4'b0000; BL = 2'b00; WLN = 2'b00; WLP = 2'b00; PRG = 1'b0;
      #1;
      exp_q.push_back(5'b00000);
      tag_q.push_back(tag);
      check_head();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      PL = 4'b0000; BL = 2'b00; WLN = 2'b00; WLP = 2'b00; PRG = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(5'b00000);
      tag_q.push_back("reset_state");
      check_head();
      @(negedge clk);
      reset = 1'b0;
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "idle");

      // Program column 1 with WLP=01: pulse after the 4th edge only
      for (int i = 1; i <= 3; i++)
         cyc(4'b1000, 2'b10, 2'b00, 2'b01, 1'b1, 5'b00000, "prog_c1_wait");
      cyc(4'b1000, 2'b10, 2'b00, 2'b01, 1'b1, 5'b10000, "prog_c1_pulse");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "prog_c1_drop");
      // Read column 1: valid after two edges, WLN masks the data
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c1_lat1");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00110, "read_c1_data");
      cyc(4'b0100, 2'b10, 2'b10, 2'b00, 1'b0, 5'b00010, "read_c1_wln10");
      cyc(4'b0100, 2'b10, 2'b01, 2'b00, 1'b0, 5'b00110, "read_c1_wln01");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c1_drop");

      // Column 0 program aborted after 3 cycles: no pulse, no commit
      for (int i = 1; i <= 3; i++)
         cyc(4'b0010, 2'b01, 2'b00, 2'b11, 1'b1, 5'b00000, "short_prog");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "short_prog_drop");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c0_lat1");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b00010, "read_c0_blank");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c0_drop");

      // Column 0: WLP=01 then WLP=10, fuses accumulate
      for (int i = 1; i <= 3; i++)
         cyc(4'b0010, 2'b01, 2'b00, 2'b01, 1'b1, 5'b00000, "prog_c0a_wait");
      cyc(4'b0010, 2'b01, 2'b00, 2'b01, 1'b1, 5'b10000, "prog_c0a_pulse");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "prog_c0a_drop");
      for (int i = 1; i <= 3; i++)
         cyc(4'b0010, 2'b01, 2'b00, 2'b10, 1'b1, 5'b00000, "prog_c0b_wait");
      cyc(4'b0010, 2'b01, 2'b00, 2'b10, 1'b1, 5'b10000, "prog_c0b_pulse");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "prog_c0b_drop");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c0_or_lat1");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b01110, "read_c0_or");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c0_or_drop");

      // PRG held 10 cycles on column 1 WLP=10: exactly one pulse
      for (int i = 1; i <= 10; i++)
         cyc(4'b1000, 2'b10, 2'b00, 2'b10, 1'b1, (i == 4) ? 5'b10000 : 5'b00000,
             "long_prg");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "long_prg_drop");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c1_both_lat1");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b01110, "read_c1_both");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c1_both_drop");

      // Reset two cycles into a program: outputs and fuses cleared
      for (int i = 1; i <= 2; i++)
         cyc(4'b0010, 2'b01, 2'b00, 2'b01, 1'b1, 5'b00000, "prog_before_reset");
      do_reset("reset_mid_prog");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "post_reset_idle");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c1_cleared_lat1");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00010, "read_c1_cleared");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c1_cleared_drop");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b00000, "read_c0_cleared_lat1");
      cyc(4'b0001, 2'b01, 2'b11, 2'b00, 1'b0, 5'b00010, "read_c0_cleared");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "read_c0_cleared_drop");

      // PL=11 on column 0: sticky fault, legal traffic afterwards ignored
      cyc(4'b0011, 2'b01, 2'b00, 2'b00, 1'b0, 5'b00001, "pl11_fault");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00001, "fault_sticky_read");
      cyc(4'b0100, 2'b10, 2'b11, 2'b00, 1'b0, 5'b00001, "fault_sticky_read2");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00001, "fault_sticky_idle");
      do_reset("reset_clears_fault");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "fault_cleared");

      // BL=11 with program bias: fault
      cyc(4'b1010, 2'b11, 2'b00, 2'b01, 1'b1, 5'b00001, "bl11_fault");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00001, "bl11_sticky");
      do_reset("reset_final");
      cyc(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000, "final_idle");

      if (exp_q.size() != 0) begin
         bad++;
         $error("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
